uart_rx: RTL and testbench

//  UART receiver for 8N1 serial frames, 16x oversampled off a fractional baud accumulator.

---
 rtl/uart_rx.sv | 88 ++++++++
 tb/tb_uart_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled from a fractional baud accumulator.
// Define UART_RX_GLITCH_FILTER_EN for majority-of-3 sampling around mid-bit.
module uart_rx #(
    parameter int BAUD              = 115200,
    parameter int SOURCE_FREQ       = 25000000,
    parameter int ACCUMULATOR_WIDTH = 16
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_complete,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int W = ACCUMULATOR_WIDTH;
    localparam longint COUNT_INC_L =
        ((longint'(BAUD) << (W - 3)) + longint'(SOURCE_FREQ >> 8)) / longint'(SOURCE_FREQ >> 7);
    localparam logic [W:0] COUNT_INC = (W + 1)'(COUNT_INC_L);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} state_t;

    state_t     state, state_next;
    logic       sync1, rxs;
    logic [W:0] acc;
    logic       tick, dp, sample, start_det;
    logic [3:0] ph;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    assign tick      = acc[W];
    assign start_det = (state == RX_IDLE) && !rxs;
    assign rx_busy   = (state != RX_IDLE);

`ifdef UART_RX_GLITCH_FILTER_EN
    // taps[1] holds rxs from the ph=7 tick, taps[0] from the ph=8 tick; decide on the ph=9 tick
    logic [1:0] taps;
    assign dp     = tick && (ph == 4'd8);
    assign sample = (taps[1] & taps[0]) | (taps[1] & rxs) | (taps[0] & rxs);
    always_ff @(posedge sourceClk or negedge reset)
        if (!reset) taps <= 2'b11;
        else if (tick && (ph == 4'd6 || ph == 4'd7)) taps <= {taps[0], rxs};
`else
    assign dp     = tick && (ph == 4'd7);
    assign sample = rxs;
`endif

    always_ff @(posedge sourceClk or negedge reset)
        if (!reset) state <= RX_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      state_next = rxs ? RX_IDLE : RX_START;
            RX_START:     state_next = !dp ? RX_START : sample ? RX_IDLE : RX_DATA;
            RX_DATA:      state_next = (dp && bit_cnt == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:      state_next = !dp ? RX_STOP : sample ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: state_next = rxs ? RX_IDLE : RX_WAIT_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            sync1        <= 1'b1;
            rxs          <= 1'b1;
            acc          <= '0;
            ph           <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_byte      <= '0;
            rx_complete  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync1        <= rx_in;
            rxs          <= sync1;
            // restart the bit-phase grid on the detected start edge
            acc          <= start_det ? '0 : {1'b0, acc[W-1:0]} + COUNT_INC;
            ph           <= (state == RX_IDLE) ? 4'd0 : ph + 4'(tick);
            bit_cnt      <= (state == RX_IDLE) ? 3'd0 : (state == RX_DATA && dp) ? bit_cnt + 3'd1 : bit_cnt;
            shreg        <= (state == RX_DATA && dp) ? {sample, shreg[7:1]} : shreg;
            rx_byte      <= (state == RX_STOP && dp && sample) ? shreg : rx_byte;
            rx_complete  <= (state == RX_STOP) && dp && sample;
            rx_frame_err <= (state == RX_STOP) && dp && !sample;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at default parameters (1 bit = 217 cycles).
module tb_uart_rx;
    localparam int BIT = 217;

    logic       clk = 1'b0, reset = 1'b0, rx_in = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_complete, rx_frame_err, rx_busy;
    int         n_tests = 0, n_fail = 0;
    int         n_cmp = 0, n_err = 0, n_both = 0;
    int         base_c, base_e;
    logic [7:0] got_q[$];

    uart_rx dut (
        .sourceClk   (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_byte     (rx_byte),
        .rx_complete (rx_complete),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_complete) begin
            n_cmp++;
            got_q.push_back(rx_byte);
        end
        if (rx_frame_err) n_err++;
        if (rx_complete && rx_frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // one 8N1 frame; spike_at >= 0 forces a 14-cycle high pulse centred on that cycle
    task automatic send(input logic [7:0] data, input logic stop, input int spike_at);
        for (int c = 0; c < 10 * BIT; c++) begin
            int   b;
            logic v;
            b = c / BIT;
            v = (b == 0) ? 1'b0 : (b == 9) ? stop : data[(b - 1) & 7];
            if (spike_at >= 0 && c >= spike_at - 7 && c < spike_at + 7) v = 1'b1;
            @(negedge clk);
            rx_in = v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic mark();
        base_c = n_cmp;
        base_e = n_err;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_byte", rx_byte, 8'h00);
        check("rst_complete", rx_complete, 0);
        check("rst_frame_err", rx_frame_err, 0);
        check("rst_busy", rx_busy, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // single frame
        mark();
        send(8'h55, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t1_count", n_cmp - base_c, 1);
        check("t1_byte", got_q[base_c], 8'h55);
        check("t1_rx_byte", rx_byte, 8'h55);
        check("t1_err", n_err - base_e, 0);
        check("t1_busy", rx_busy, 0);

        // back-to-back frames
        mark();
        send(8'hA5, 1'b1, -1);
        send(8'h3C, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t2_count", n_cmp - base_c, 2);
        check("t2_byte0", got_q[base_c], 8'hA5);
        check("t2_byte1", got_q[base_c + 1], 8'h3C);

        // false start
        mark();
        @(negedge clk);
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        check("t3_busy_mid", rx_busy, 1);
        repeat (30) @(negedge clk);
        rx_in = 1'b1;
        repeat (300) @(negedge clk);
        check("t3_busy_end", rx_busy, 0);
        check("t3_count", n_cmp - base_c, 0);
        check("t3_err", n_err - base_e, 0);

        // framing error, held break, recovery
        do_reset();
        mark();
        send(8'hFF, 1'b0, -1);
        repeat (2000) @(negedge clk);
        check("t4_err", n_err - base_e, 1);
        check("t4_count_low", n_cmp - base_c, 0);
        check("t4_byte_low", rx_byte, 8'h00);
        check("t4_busy_low", rx_busy, 1);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_busy_rel", rx_busy, 0);
        send(8'h81, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t4_count", n_cmp - base_c, 1);
        check("t4_byte", rx_byte, 8'h81);
        check("t4_err_end", n_err - base_e, 1);

        // async reset during data bit 4
        @(negedge clk);
        rx_in = 1'b0;
        repeat (5 * BIT + 100) @(negedge clk);
        check("t5_busy_pre", rx_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_byte_rst", rx_byte, 8'h00);
        check("t5_busy_rst", rx_busy, 0);
        check("t5_complete_rst", rx_complete, 0);
        check("t5_err_rst", rx_frame_err, 0);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        mark();
        send(8'h12, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t5_byte", rx_byte, 8'h12);
        check("t5_count", n_cmp - base_c, 1);

        // spike on the ph=8 tick of data bit 3: 3 detect cycles + 72 ticks -> cycle 978
        do_reset();
        mark();
        send(8'h00, 1'b1, 978);
        repeat (5) @(negedge clk);
        check("t6_count", n_cmp - base_c, 1);
`ifdef UART_RX_GLITCH_FILTER_EN
        check("t6_byte", rx_byte, 8'h00);
`else
        check("t6_byte", rx_byte, 8'h08);
`endif

        check("pulses_exclusive", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
